// File: rtl/sr_reg_pkg.sv
// -----------------------------------------------------------------------------
// sr_reg_pkg
// Shared encodings for the sr_reg_file register bank.
//   op_e    : write-port operation codes (LOAD / SET / CLR / TGL)
//   state_e : clear-all sequencer states (IDLE / CLEARING)
// -----------------------------------------------------------------------------
package sr_reg_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,   // reg <= wdata
      OP_SET  = 2'b01,   // reg <= reg | wdata
      OP_CLR  = 2'b10,   // reg <= reg & ~wdata
      OP_TGL  = 2'b11    // reg <= reg ^ wdata
   } op_e;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_CLEARING = 1'b1
   } state_e;

endpackage

// File: rtl/sr_reg_file_if.sv
// -----------------------------------------------------------------------------
// sr_reg_file_if
// Bus bundle between the instruction decoder / ALU operand muxes and the
// register bank.
//   Parameters : WIDTH (bits per register), DEPTH (number of registers)
//   master     : drives we, op, waddr, wdata, raddr_a, raddr_b, clr_all;
//                receives rdata_a, rdata_b, busy
//   slave      : the register bank (mirror directions)
// -----------------------------------------------------------------------------
interface sr_reg_file_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             we;
   logic [1:0]       op;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic [AW-1:0]    raddr_a;
   logic [AW-1:0]    raddr_b;
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;
   logic             clr_all;
   logic             busy;

   modport master (
      output we, op, waddr, wdata, raddr_a, raddr_b, clr_all,
      input  rdata_a, rdata_b, busy
   );

   modport slave (
      input  we, op, waddr, wdata, raddr_a, raddr_b, clr_all,
      output rdata_a, rdata_b, busy
   );

endinterface

// File: rtl/sr_reg_cell.sv
// -----------------------------------------------------------------------------
// sr_reg_cell
// One WIDTH-bit storage word with bitwise set/clear/toggle/load decode.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (word -> 0)
//   i_we    : write enable for this word (already qualified by the top)
//   i_op    : operation code (sr_reg_pkg::op_e values)
//   i_wdata : load data / bit mask
//   i_clr   : synchronous clear, wins over i_we
//   o_q     : current stored value
//   o_next  : value the word will hold after the next edge (used for
//             write-through reads)
// -----------------------------------------------------------------------------
module sr_reg_cell
   import sr_reg_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_we,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_next
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_op_result;

   always_comb begin
      w_op_result = r_q;
      case (i_op)
         OP_LOAD: w_op_result = i_wdata;
         OP_SET:  w_op_result = r_q | i_wdata;
         OP_CLR:  w_op_result = r_q & ~i_wdata;
         OP_TGL:  w_op_result = r_q ^ i_wdata;
         default: w_op_result = r_q;
      endcase
   end

   always_comb begin
      if (i_clr) begin
         o_next = '0;
      end else if (i_we) begin
         o_next = w_op_result;
      end else begin
         o_next = r_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= o_next;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/sr_reg_file.sv
// -----------------------------------------------------------------------------
// sr_reg_file
// Clocked multi-word SR-style register bank: one write port with bitwise
// LOAD/SET/CLR/TGL, two registered read ports and a sequenced clear-all.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (regs, read data, sequencer -> 0)
//   bus : sr_reg_file_if.slave
//         we/op/waddr/wdata     write port
//         raddr_a/raddr_b       read addresses
//         rdata_a/rdata_b       registered read data (1-cycle latency)
//         clr_all               one-cycle request to zero all registers
//         busy                  high while the clear sequence runs
// Build option:
//   SR_REG_FILE_BYPASS_EN  defined   -> reads return the value a register
//                                       will hold after this edge (write or
//                                       sequenced clear is visible at once)
//                          undefined -> reads return the pre-edge value
// -----------------------------------------------------------------------------
module sr_reg_file
   import sr_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   sr_reg_file_if.slave bus
);

   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

`ifdef SR_REG_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   state_e           r_state;
   state_e           w_state_next;
   logic [AW-1:0]    r_index;
   logic [AW-1:0]    w_index_next;
   logic             w_busy;
   logic             w_clr_accept;
   logic             w_wr_ok;

   logic [WIDTH-1:0] w_q      [DEPTH];
   logic [WIDTH-1:0] w_next   [DEPTH];
   logic [WIDTH-1:0] w_rd_src [DEPTH];
   logic [DEPTH-1:0] w_cell_we;
   logic [DEPTH-1:0] w_cell_clr;

   logic [WIDTH-1:0] r_rdata_a;
   logic [WIDTH-1:0] r_rdata_b;

   // ---------------------------------------------------------------- clear FSM
   assign w_busy       = (r_state == ST_CLEARING);
   assign w_clr_accept = (r_state == ST_IDLE) && bus.clr_all;
   // A write is dropped while clearing and on the cycle the clear is taken,
   // so a register never sees a write and a sequenced clear together.
   assign w_wr_ok      = bus.we && !w_busy && !w_clr_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_index <= '0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      case (r_state)
         ST_IDLE: begin
            if (bus.clr_all) begin
               w_state_next = ST_CLEARING;
               w_index_next = '0;
            end
         end
         ST_CLEARING: begin
            // Exit after the last word rather than letting the index wrap.
            if (r_index == LAST_IDX) begin
               w_state_next = ST_IDLE;
               w_index_next = '0;
            end else begin
               w_index_next = r_index + 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_index_next = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- storage
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
         assign w_cell_we[gi]  = w_wr_ok && (bus.waddr == AW'(gi));
         assign w_cell_clr[gi] = w_busy && (r_index == AW'(gi));

         sr_reg_cell #(
            .WIDTH (WIDTH)
         ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_cell_we[gi]),
            .i_op    (bus.op),
            .i_wdata (bus.wdata),
            .i_clr   (w_cell_clr[gi]),
            .o_q     (w_q[gi]),
            .o_next  (w_next[gi])
         );

         // Write-through reads take the cell's post-edge value, which already
         // folds in both the write and the sequenced clear.
         assign w_rd_src[gi] = BYPASS ? w_next[gi] : w_q[gi];
      end
   endgenerate

   // ---------------------------------------------------------------- read ports
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         r_rdata_a <= w_rd_src[bus.raddr_a];
         r_rdata_b <= w_rd_src[bus.raddr_b];
      end
   end

   assign bus.rdata_a = r_rdata_a;
   assign bus.rdata_b = r_rdata_b;
   assign bus.busy    = w_busy;

endmodule

// File: tb/tb_sr_reg_file.sv
// -----------------------------------------------------------------------------
// tb_sr_reg_file
// Self-checking bench for sr_reg_file (WIDTH=4, DEPTH=4). Directed steps
// followed by random traffic, compared against an array-based model.
// -----------------------------------------------------------------------------
module tb_sr_reg_file;
   import sr_reg_pkg::*;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sr_reg_file_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   sr_reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [3:0] mem [DEPTH];
   int         clr_left;
   int         clr_idx;
   logic [3:0] exp_a;
   logic [3:0] exp_b;

   function automatic logic [3:0] apply_op(input logic [1:0] op,
                                           input logic [3:0] v,
                                           input logic [3:0] m);
      case (op)
         2'd0:    return m;
         2'd1:    return v | m;
         2'd2:    return v & ~m;
         default: return v ^ m;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem[i] = 4'd0;
      clr_left = 0;
      clr_idx  = 0;
      exp_a    = 4'd0;
      exp_b    = 4'd0;
   endtask

   // Apply one cycle of inputs, advance one edge, update the model and check.
   task automatic step(input bit we, input logic [1:0] op, input int wa,
                       input logic [3:0] wd, input int ra, input int rb,
                       input bit ca, input string tag);
      logic [3:0] pre [DEPTH];
      bus.we      = we;
      bus.op      = op;
      bus.waddr   = wa[1:0];
      bus.wdata   = wd;
      bus.raddr_a = ra[1:0];
      bus.raddr_b = rb[1:0];
      bus.clr_all = ca;
      @(posedge clk);
      for (int i = 0; i < DEPTH; i++) pre[i] = mem[i];
      if (clr_left > 0) begin
         mem[clr_idx] = 4'd0;
         clr_idx++;
         clr_left--;
      end else if (ca) begin
         clr_left = DEPTH;
         clr_idx  = 0;
      end else if (we) begin
         mem[wa] = apply_op(op, mem[wa], wd);
      end
`ifdef SR_REG_FILE_BYPASS_EN
      exp_a = mem[ra];
      exp_b = mem[rb];
`else
      exp_a = pre[ra];
      exp_b = pre[rb];
`endif
      #1;
      check({tag, "_rdata_a"}, bus.rdata_a, exp_a);
      check({tag, "_rdata_b"}, bus.rdata_b, exp_b);
      check({tag, "_busy"}, {3'b0, bus.busy}, {3'b0, clr_left > 0});
      $display("step %s we=%0d op=%0d wa=%0d wd=%b ra=%0d rb=%0d clr=%0d -> a=%b b=%b busy=%0d",
               tag, we, op, wa, wd, ra, rb, ca, bus.rdata_a, bus.rdata_b, bus.busy);
   endtask

   task automatic idle(input int ra, input int rb, input string tag);
      step(1'b0, OP_LOAD, 0, 4'd0, ra, rb, 1'b0, tag);
   endtask

   logic [1:0] ops_op  [4];
   logic [3:0] ops_dat [4];
   logic [3:0] ops_exp [4];

   initial begin
      bus.we = 0; bus.op = 0; bus.waddr = 0; bus.wdata = 0;
      bus.raddr_a = 0; bus.raddr_b = 0; bus.clr_all = 0;
      model_reset();

      // --- reset state
      #1;
      check("reset_rdata_a", bus.rdata_a, 4'd0);
      check("reset_rdata_b", bus.rdata_b, 4'd0);
      check("reset_busy", {3'b0, bus.busy}, 4'd0);
      #11 rst = 1'b0;
      @(posedge clk); #1;
      idle(0, 1, "rst_read01");
      idle(2, 3, "rst_read23");
      idle(0, 0, "rst_flush");

      // --- bitwise ops on reg 2
      ops_op[0] = OP_LOAD; ops_dat[0] = 4'b0101; ops_exp[0] = 4'b0101;
      ops_op[1] = OP_SET;  ops_dat[1] = 4'b0010; ops_exp[1] = 4'b0111;
      ops_op[2] = OP_CLR;  ops_dat[2] = 4'b0100; ops_exp[2] = 4'b0011;
      ops_op[3] = OP_TGL;  ops_dat[3] = 4'b1001; ops_exp[3] = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, ops_op[k], 2, ops_dat[k], 0, 0, 1'b0, "ops_wr");
         idle(2, 2, "ops_rd");
         check("ops_literal", bus.rdata_a, ops_exp[k]);
      end

      // --- dual read
      step(1'b1, OP_LOAD, 1, 4'b1100, 0, 0, 1'b0, "dual_wr1");
      step(1'b1, OP_LOAD, 3, 4'b0011, 0, 0, 1'b0, "dual_wr3");
      idle(1, 3, "dual_rd");
      check("dual_a_literal", bus.rdata_a, 4'b1100);
      check("dual_b_literal", bus.rdata_b, 4'b0011);

      // --- same-cycle write/read of reg 0
      step(1'b1, OP_LOAD, 0, 4'b0000, 1, 1, 1'b0, "same_init");
      step(1'b1, OP_LOAD, 0, 4'b1111, 0, 0, 1'b0, "same_wr");
`ifdef SR_REG_FILE_BYPASS_EN
      check("same_cycle_literal", bus.rdata_a, 4'b1111);
`else
      check("same_cycle_literal", bus.rdata_a, 4'b0000);
`endif
      idle(0, 0, "same_next");
      check("same_next_literal", bus.rdata_a, 4'b1111);

      // --- clear-all; write on accept cycle, writes during busy, re-request
      for (int i = 0; i < DEPTH; i++) step(1'b1, OP_LOAD, i, 4'b1111, 0, 1, 1'b0, "ca_fill");
      step(1'b1, OP_LOAD, 1, 4'b0000, 2, 3, 1'b1, "ca_req");
      check("ca_busy_literal", {3'b0, bus.busy}, 4'd1);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, OP_LOAD, 3 - k, 4'b0101, 3, 2, (k == 1), "ca_busy");
         check("ca_busy_literal", {3'b0, bus.busy}, 4'd1);
      end
      step(1'b1, OP_LOAD, 3, 4'b0101, 1, 0, 1'b0, "ca_last");
      check("ca_done_literal", {3'b0, bus.busy}, 4'd0);
      idle(0, 1, "ca_rd01");
      idle(2, 3, "ca_rd23");
      check("ca_zero_a_literal", bus.rdata_a, 4'd0);
      check("ca_zero_b_literal", bus.rdata_b, 4'd0);
      idle(0, 1, "ca_rd01b");
      check("ca_zero_a0_literal", bus.rdata_a, 4'd0);
      check("ca_zero_b1_literal", bus.rdata_b, 4'd0);

      // --- reset during the second clearing cycle
      for (int i = 0; i < DEPTH; i++) step(1'b1, OP_LOAD, i, 4'b1111, 0, 0, 1'b0, "rc_fill");
      step(1'b0, OP_LOAD, 0, 4'd0, 3, 2, 1'b1, "rc_req");
      idle(3, 2, "rc_clr1");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("rc_busy_literal", {3'b0, bus.busy}, 4'd0);
      check("rc_rdata_a_literal", bus.rdata_a, 4'd0);
      check("rc_rdata_b_literal", bus.rdata_b, 4'd0);
      #2 rst = 1'b0;
      idle(0, 1, "rc_rd01");
      check("rc_busy_after_literal", {3'b0, bus.busy}, 4'd0);
      idle(2, 3, "rc_rd23");
      check("rc_zero_a_literal", bus.rdata_a, 4'd0);
      check("rc_zero_b_literal", bus.rdata_b, 4'd0);
      step(1'b1, OP_LOAD, 2, 4'b0110, 0, 1, 1'b0, "rc_load");
      idle(2, 2, "rc_load_rd");
      check("rc_load_literal", bus.rdata_a, 4'b0110);

      // --- random traffic against the model
      for (int n = 0; n < 300; n++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15)),
              int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
              ($urandom_range(0, 19) == 0), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
